// File: rtl/axi_cache_pkg.sv
// Shared types for the AXI burst address decoder: burst kinds, FSM states
// and the AXI 4 KB page constant.
package axi_cache_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10
    } burst_e;

    typedef enum logic {
        IDLE,
        BURST
    } state_e;

    localparam int PAGE_BITS = 12;

endpackage

// File: rtl/burst_next_addr.sv
// Combinational AXI next-beat address: FIXED holds, INCR aligns then steps,
// WRAP steps and folds back to the wrap window base.
module burst_next_addr
    import axi_cache_pkg::*;
#(
    parameter int ADDR_SIZE = 32,
    parameter int LEN_W     = 8
) (
    input  logic [ADDR_SIZE-1:0] addr_i,
    input  logic [2:0]           size_i,
    input  logic [LEN_W-1:0]     len_i,
    input  logic [1:0]           burst_i,
    input  logic [ADDR_SIZE-1:0] wrap_lo_i,
    output logic [ADDR_SIZE-1:0] next_o
);

    logic [ADDR_SIZE-1:0] bytes;
    logic [ADDR_SIZE-1:0] total;
    logic [ADDR_SIZE-1:0] step;

    always_comb begin
        bytes  = ADDR_SIZE'(1) << size_i;
        total  = (ADDR_SIZE'(len_i) + ADDR_SIZE'(1)) << size_i;
        step   = addr_i + bytes;
        next_o = addr_i;
        case (burst_e'(burst_i))
            FIXED:   next_o = addr_i;
            INCR:    next_o = (addr_i & ~(bytes - ADDR_SIZE'(1))) + bytes;
            WRAP:    next_o = (step == wrap_lo_i + total) ? wrap_lo_i : step;
            default: next_o = addr_i;
        endcase
    end

endmodule

// File: rtl/axi_burst_addr_decode.sv
// AXI burst descriptor to per-beat cache address stream (tag/index/offset),
// with descriptor legality checking and back-to-back burst acceptance.
module axi_burst_addr_decode
    import axi_cache_pkg::*;
#(
    parameter int ADDR_SIZE  = 32,
    parameter int BLOCK_SIZE = 6,
    parameter int INDEX_SIZE = 7,
    parameter int LEN_W      = 8,
    parameter int MAX_SIZE   = 3,
    localparam int TAG_SIZE  = ADDR_SIZE - BLOCK_SIZE - INDEX_SIZE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [ADDR_SIZE-1:0]  in_addr,
    input  logic [LEN_W-1:0]      in_len,
    input  logic [2:0]            in_size,
    input  logic [1:0]            in_burst,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_SIZE-1:0]  out_addr,
    output logic [TAG_SIZE-1:0]   out_tag,
    output logic [INDEX_SIZE-1:0] out_index,
    output logic [BLOCK_SIZE-1:0] out_block,
    output logic [LEN_W-1:0]      out_beat,
    output logic                  out_last,
    output logic                  out_line_new,
    output logic                  err
);

    state_e                 state_q, state_d;
    logic [ADDR_SIZE-1:0]   addr_q, addr_d;
    logic [LEN_W-1:0]       beat_q, beat_d;
    logic                   line_new_q, line_new_d;
    logic                   err_q, err_d;

    logic [LEN_W-1:0]       len_q;
    logic [2:0]             size_q;
    logic [1:0]             burst_q;
    logic [ADDR_SIZE-1:0]   wrap_lo_q;

    logic [ADDR_SIZE-1:0]   bytes_in, total_in, incr_last, wrap_lo_in, next_addr;
    logic                   legal, accept, hs, load;

    burst_next_addr #(
        .ADDR_SIZE (ADDR_SIZE),
        .LEN_W     (LEN_W)
    ) u_next (
        .addr_i    (addr_q),
        .size_i    (size_q),
        .len_i     (len_q),
        .burst_i   (burst_q),
        .wrap_lo_i (wrap_lo_q),
        .next_o    (next_addr)
    );

    // Descriptor legality is judged on the raw inputs so rejection costs no extra cycle.
    always_comb begin
        bytes_in   = ADDR_SIZE'(1) << in_size;
        total_in   = (ADDR_SIZE'(in_len) + ADDR_SIZE'(1)) << in_size;
        incr_last  = (in_addr & ~(bytes_in - ADDR_SIZE'(1))) + total_in - ADDR_SIZE'(1);
        wrap_lo_in = in_addr & ~(total_in - ADDR_SIZE'(1));
        legal      = 1'b1;
        if (in_burst == 2'b11)
            legal = 1'b0;
        if (int'(in_size) > MAX_SIZE)
            legal = 1'b0;
        if (in_burst == WRAP) begin
            if (!(in_len == LEN_W'(1) || in_len == LEN_W'(3) ||
                  in_len == LEN_W'(7) || in_len == LEN_W'(15)))
                legal = 1'b0;
            if ((in_addr & (bytes_in - ADDR_SIZE'(1))) != '0)
                legal = 1'b0;
        end
        if (in_burst == INCR &&
            incr_last[ADDR_SIZE-1:PAGE_BITS] != in_addr[ADDR_SIZE-1:PAGE_BITS])
            legal = 1'b0;
    end

    always_comb begin
        out_valid  = (state_q == BURST);
        out_last   = out_valid && (beat_q == len_q);
        hs         = out_valid && out_ready;
        in_ready   = (state_q == IDLE) || (hs && out_last);
        accept     = in_valid && in_ready;
        state_d    = state_q;
        addr_d     = addr_q;
        beat_d     = beat_q;
        line_new_d = line_new_q;
        err_d      = 1'b0;
        load       = 1'b0;
        if (accept) begin
            if (legal) begin
                state_d    = BURST;
                addr_d     = in_addr;
                beat_d     = '0;
                line_new_d = 1'b1;
                load       = 1'b1;
            end else begin
                state_d    = IDLE;
                line_new_d = 1'b0;
                err_d      = 1'b1;
            end
        end else if (hs && out_last) begin
            state_d    = IDLE;
            line_new_d = 1'b0;
        end else if (hs) begin
            addr_d     = next_addr;
            beat_d     = beat_q + LEN_W'(1);
            line_new_d = (next_addr[ADDR_SIZE-1:BLOCK_SIZE] != addr_q[ADDR_SIZE-1:BLOCK_SIZE]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            beat_q     <= '0;
            line_new_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            beat_q     <= beat_d;
            line_new_q <= line_new_d;
            err_q      <= err_d;
        end
    end

    // Descriptor fields are only read while BURST, so they need no reset.
    always_ff @(posedge clk) begin
        if (load) begin
            len_q     <= in_len;
            size_q    <= in_size;
            burst_q   <= in_burst;
            wrap_lo_q <= wrap_lo_in;
        end
    end

    assign out_addr     = addr_q;
    assign out_tag      = addr_q[ADDR_SIZE-1:INDEX_SIZE+BLOCK_SIZE];
    assign out_index    = addr_q[INDEX_SIZE+BLOCK_SIZE-1:BLOCK_SIZE];
    assign out_block    = addr_q[BLOCK_SIZE-1:0];
    assign out_beat     = beat_q;
    assign out_line_new = line_new_q;
    assign err          = err_q;

endmodule

// File: tb/tb_axi_burst_addr_decode.sv
// Bench for axi_burst_addr_decode: directed vector table, hand-written stall,
// back-to-back and async-reset sequences, then randomized bursts vs a beat-indexed model.
module tb_axi_burst_addr_decode;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_addr = '0;
    logic [7:0]  in_len = '0;
    logic [2:0]  in_size = '0;
    logic [1:0]  in_burst = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_addr;
    logic [18:0] out_tag;
    logic [6:0]  out_index;
    logic [5:0]  out_block;
    logic [7:0]  out_beat;
    logic        out_last;
    logic        out_line_new;
    logic        err;

    int checks = 0;
    int failures = 0;
    logic [31:0] got[$];
    logic        last_err;

    axi_burst_addr_decode dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_addr      (in_addr),
        .in_len       (in_len),
        .in_size      (in_size),
        .in_burst     (in_burst),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_addr     (out_addr),
        .out_tag      (out_tag),
        .out_index    (out_index),
        .out_block    (out_block),
        .out_beat     (out_beat),
        .out_last     (out_last),
        .out_line_new (out_line_new),
        .err          (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [7:0]  l;
        logic [2:0]  s;
        logic [1:0]  b;
        logic        e;
        logic [31:0] ea[4];
    } vec_t;

    vec_t tbl[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic bit model_legal(input logic [31:0] a, input logic [7:0] l,
                                       input logic [2:0] s, input logic [1:0] b);
        logic [31:0] bb, t, start, lastb;
        bb = 32'd1 << s;
        t  = bb * (32'(l) + 1);
        if (b == 2'b11) return 0;
        if (s > 3) return 0;
        if (b == 2'b10) begin
            if (!(l == 1 || l == 3 || l == 7 || l == 15)) return 0;
            if (a % bb != 0) return 0;
        end
        if (b == 2'b01) begin
            start = a - (a % bb);
            lastb = start + t - 1;
            if ((lastb >> 12) != (a >> 12)) return 0;
        end
        return 1;
    endfunction

    // Address of beat k computed directly, not by stepping.
    function automatic logic [31:0] model_addr(input logic [31:0] a, input logic [7:0] l,
                                               input logic [2:0] s, input logic [1:0] b,
                                               input int k);
        logic [31:0] bb, t, lo;
        bb = 32'd1 << s;
        t  = bb * (32'(l) + 1);
        case (b)
            2'b00: return a;
            2'b01: return (k == 0) ? a : (a - (a % bb)) + 32'(k) * bb;
            default: begin
                lo = a - (a % t);
                return lo + (((a - lo) + 32'(k) * bb) % t);
            end
        endcase
    endfunction

    task automatic set_vec(input int i, input logic [31:0] a, input logic [7:0] l,
                           input logic [2:0] s, input logic [1:0] b, input logic e,
                           input logic [31:0] a0, input logic [31:0] a1,
                           input logic [31:0] a2, input logic [31:0] a3);
        tbl[i].a = a; tbl[i].l = l; tbl[i].s = s; tbl[i].b = b; tbl[i].e = e;
        tbl[i].ea[0] = a0; tbl[i].ea[1] = a1; tbl[i].ea[2] = a2; tbl[i].ea[3] = a3;
    endtask

    task automatic run_burst(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                             input logic [1:0] b, input bit rnd_ready);
        int k;
        int cyc;
        logic [31:0] ea, pa;
        bit exp_new;
        got.delete();
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1'b1; in_addr = a; in_len = l; in_size = s; in_burst = b;
        out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        last_err = err;
        if (!model_legal(a, l, s, b)) begin
            chk("err_pulse", err, 1);
            chk("err_no_valid", out_valid, 0);
            tick();
            chk("err_one_cycle", err, 0);
            chk("err_still_idle", out_valid, 0);
            return;
        end
        chk("err_low", err, 0);
        k = 0;
        cyc = 0;
        pa = '0;
        while (k <= int'(l) && cyc < 2000) begin
            if (!out_valid) begin
                chk("valid_in_burst", out_valid, 1);
                break;
            end
            ea = model_addr(a, l, s, b, k);
            exp_new = (k == 0) || (ea[31:6] != pa[31:6]);
            chk("beat_addr", out_addr, ea);
            chk("beat_num", out_beat, 8'(k));
            chk("beat_last", out_last, (k == int'(l)));
            chk("line_new", out_line_new, exp_new);
            chk("tag", out_tag, ea[31:13]);
            chk("index", out_index, ea[12:6]);
            chk("block", out_block, ea[5:0]);
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            if (out_ready) begin
                got.push_back(ea);
                pa = ea;
                k++;
            end
            cyc++;
        end
        if (cyc >= 2000) chk("burst_timeout", 0, 1);
        out_ready = 1'b0;
        chk("idle_after_burst", out_valid, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [7:0]  l;
        logic [2:0]  s;
        logic [1:0]  b;
        int          n;

        #2 rst = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_line_new", out_line_new, 0);
        chk("rst_err", err, 0);
        chk("rst_addr", out_addr, 0);
        chk("rst_beat", out_beat, 0);
        chk("rst_in_ready", in_ready, 1);
        tick();
        tick();
        rst = 1'b0;
        tick();

        set_vec(0, 32'h1000, 8'd3, 3'd3, 2'b01, 1'b0, 32'h1000, 32'h1008, 32'h1010, 32'h1018);
        set_vec(1, 32'h1038, 8'd3, 3'd3, 2'b10, 1'b0, 32'h1038, 32'h1020, 32'h1028, 32'h1030);
        set_vec(2, 32'h103C, 8'd1, 3'd3, 2'b01, 1'b0, 32'h103C, 32'h1040, 32'h0, 32'h0);
        set_vec(3, 32'h1000, 8'd0, 3'd2, 2'b11, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
        set_vec(4, 32'h1000, 8'd2, 3'd3, 2'b10, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
        set_vec(5, 32'h0FF8, 8'd1, 3'd3, 2'b01, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
        set_vec(6, 32'h2004, 8'd2, 3'd2, 2'b00, 1'b0, 32'h2004, 32'h2004, 32'h2004, 32'h0);
        set_vec(7, 32'h1000, 8'd0, 3'd4, 2'b01, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
        set_vec(8, 32'h1004, 8'd1, 3'd3, 2'b10, 1'b1, 32'h0, 32'h0, 32'h0, 32'h0);
        set_vec(9, 32'h5000, 8'd0, 3'd0, 2'b01, 1'b0, 32'h5000, 32'h0, 32'h0, 32'h0);

        for (int i = 0; i < 10; i++) begin
            run_burst(tbl[i].a, tbl[i].l, tbl[i].s, tbl[i].b, 1'b0);
            chk("tbl_err", last_err, tbl[i].e);
            if (!tbl[i].e) begin
                chk("tbl_beats", got.size(), int'(tbl[i].l) + 1);
                for (int j = 0; j <= int'(tbl[i].l) && j < 4 && j < got.size(); j++)
                    chk("tbl_addr", got[j], tbl[i].ea[j]);
            end
            tick();
        end

        // Stall mid-burst: outputs must freeze while out_ready is low.
        in_valid = 1'b1; in_addr = 32'h2000; in_len = 8'd7; in_size = 3'd2; in_burst = 2'b01;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        chk("stall_pre_addr", out_addr, 32'h2008);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_addr", out_addr, 32'h2008);
            chk("stall_beat", out_beat, 8'd2);
            chk("stall_valid", out_valid, 1);
        end
        out_ready = 1'b1;
        tick();
        chk("post_stall_addr", out_addr, 32'h200C);
        n = 0;
        while (out_valid && n < 20) begin
            tick();
            n++;
        end
        chk("stall_drain_beats", n, 5);
        chk("stall_drain_idle", out_valid, 0);

        // Back-to-back: next descriptor taken on the last-beat handshake.
        in_valid = 1'b1; in_addr = 32'h3000; in_len = 8'd1; in_size = 3'd3; in_burst = 2'b01;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        chk("b2b_last", out_last, 1);
        chk("b2b_in_ready", in_ready, 1);
        in_valid = 1'b1; in_addr = 32'h4004; in_len = 8'd3; in_size = 3'd2; in_burst = 2'b10;
        tick();
        in_valid = 1'b0;
        chk("b2b_valid", out_valid, 1);
        chk("b2b_addr0", out_addr, 32'h4004);
        chk("b2b_beat0", out_beat, 8'd0);
        chk("b2b_line_new", out_line_new, 1);
        tick();
        chk("b2b_addr1", out_addr, 32'h4008);
        tick();
        chk("b2b_addr2", out_addr, 32'h400C);
        tick();
        chk("b2b_addr3_wrap", out_addr, 32'h4000);
        chk("b2b_last3", out_last, 1);
        tick();
        chk("b2b_idle", out_valid, 0);

        // Asynchronous reset between edges aborts a burst.
        in_valid = 1'b1; in_addr = 32'h6000; in_len = 8'd7; in_size = 3'd3; in_burst = 2'b01;
        tick();
        in_valid = 1'b0;
        tick();
        chk("arst_pre_addr", out_addr, 32'h6008);
        #2 rst = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_in_ready", in_ready, 1);
        chk("arst_addr", out_addr, 0);
        chk("arst_beat", out_beat, 0);
        #2 rst = 1'b0;
        tick();
        chk("arst_aborted", out_valid, 0);
        out_ready = 1'b0;

        for (int r = 0; r < 60; r++) begin
            b = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            s = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            if (b == 2'b10 && $urandom_range(0, 4) != 0) begin
                n = $urandom_range(0, 3);
                l = 8'((2 << n) - 1);
            end else begin
                l = 8'($urandom_range(0, 15));
            end
            a = $urandom;
            if ($urandom_range(0, 2) == 0) a = {a[31:12], 4'hF, a[7:0]};
            if (b == 2'b10 && $urandom_range(0, 3) != 0) a = a & ~((32'd1 << s) - 1);
            run_burst(a, l, s, b, 1'b1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
